// File: rtl/uart_pkg.sv
// Purpose: shared types and helpers for the oversampled UART blocks.
// Contents: receiver FSM state encoding, baud divider calculation, oversample default.
// Used by: uart_rx_oversampled, uart_baud_tick users (receiver and planned transmitter).
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Clock cycles per oversample tick, rounded to nearest, never below 1.
    function automatic int calc_div(input longint clk_freq, input longint baud,
                                    input longint oversample);
        longint den;
        longint q;
        den = baud * oversample;
        q   = (clk_freq + den / 2) / den;
        if (q < 1) q = 1;
        return int'(q);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Purpose: free-running divider producing a one-cycle tick every DIV clocks.
// Ports: clk, rst (sync active-low), tick (high one cycle in every DIV; always high when DIV==1).
// Latency: tick is decoded combinationally from the counter; no backpressure.
module uart_baud_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// Purpose: 8N1 receiver; syncs RxD, oversamples, 2-of-3 majority per bit, checks start/stop.
// Ports: clk, rst (sync active-low), RxD in; RxD_data_ready / RxD_frame_err one-cycle strobes,
//        RxD_data last good byte, RxD_idle line quiet for IDLE_BITS bit-times. No backpressure.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int IDLE_BITS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic       RxD_data_ready,
    output logic [7:0] RxD_data,
    output logic       RxD_frame_err,
    output logic       RxD_idle
);

    localparam int DIV = calc_div(longint'(CLK_FREQ), longint'(BAUD), longint'(OVERSAMPLE));
    localparam int CW  = $clog2(OVERSAMPLE);

    // Three samples around mid-bit; the bit is decided on the third.
    localparam logic [CW-1:0] S_A   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] S_B   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] S_C   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] S_END = CW'(OVERSAMPLE - 1);

    localparam int IDLE_MAX = IDLE_BITS * OVERSAMPLE;
    localparam int IW       = $clog2(IDLE_MAX + 1);
    localparam logic [IW-1:0] IDLE_TOP = IW'(IDLE_MAX);

    logic            tick;
    logic            sync1;
    logic            rxs;
    logic [1:0]      warm;
    rx_state_t       state,    state_n;
    logic [CW-1:0]   cnt,      cnt_n;
    logic [2:0]      bit_idx,  bit_idx_n;
    logic [7:0]      shreg,    shreg_n;
    logic            smp_a,    smp_a_n;
    logic            smp_b,    smp_b_n;
    logic            armed,    armed_n;
    logic [IW-1:0]   idle_cnt, idle_cnt_n;
    logic [7:0]      data_n;
    logic            ready_n;
    logic            err_n;
    logic            maj;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign maj      = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);
    assign RxD_idle = (idle_cnt == IDLE_TOP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1          <= 1'b1;
            rxs            <= 1'b1;
            warm           <= 2'b00;
            state          <= ST_IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            smp_a          <= 1'b1;
            smp_b          <= 1'b1;
            armed          <= 1'b0;
            idle_cnt       <= '0;
            RxD_data       <= 8'h00;
            RxD_data_ready <= 1'b0;
            RxD_frame_err  <= 1'b0;
        end else begin
            sync1          <= RxD;
            rxs            <= sync1;
            // The synchroniser's reset value is not line information; arming
            // waits until both flops have captured the real pin.
            warm           <= {warm[0], 1'b1};
            state          <= state_n;
            cnt            <= cnt_n;
            bit_idx        <= bit_idx_n;
            shreg          <= shreg_n;
            smp_a          <= smp_a_n;
            smp_b          <= smp_b_n;
            armed          <= armed_n;
            idle_cnt       <= idle_cnt_n;
            RxD_data       <= data_n;
            RxD_data_ready <= ready_n;
            RxD_frame_err  <= err_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        smp_a_n    = smp_a;
        smp_b_n    = smp_b;
        armed_n    = armed;
        idle_cnt_n = idle_cnt;
        data_n     = RxD_data;
        ready_n    = 1'b0;
        err_n      = 1'b0;

        if (tick) begin
            if (rxs && warm[1]) armed_n = 1'b1;

            if (state == ST_IDLE) begin
                if (idle_cnt != IDLE_TOP) idle_cnt_n = idle_cnt + 1'b1;
                if (armed && !rxs) begin
                    state_n    = ST_START;
                    cnt_n      = '0;
                    idle_cnt_n = '0;
                end
            end else begin
                // OVERSAMPLE is a power of two, so the counter wraps per bit.
                cnt_n = cnt + 1'b1;
                if (cnt == S_A) smp_a_n = rxs;
                if (cnt == S_B) smp_b_n = rxs;

                unique case (state)
                    ST_START: begin
                        if (cnt == S_C && maj) begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                        end else if (cnt == S_END) begin
                            state_n   = ST_DATA;
                            bit_idx_n = '0;
                        end
                    end
                    ST_DATA: begin
                        if (cnt == S_C) shreg_n = {maj, shreg[7:1]};
                        if (cnt == S_END) begin
                            if (bit_idx == 3'd7) begin
                                state_n = ST_STOP;
                            end else begin
                                bit_idx_n = bit_idx + 1'b1;
                            end
                        end
                    end
                    ST_STOP: begin
                        // Leave mid-stop-bit so a back-to-back start edge is seen.
                        if (cnt == S_C) begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                            if (maj) begin
                                data_n  = shreg;
                                ready_n = 1'b1;
                            end else begin
                                err_n   = 1'b1;
                                armed_n = 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_n = ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
module tb_uart_rx_oversampled;

    logic       clk;
    logic       rst;
    logic       RxD;
    logic       RxD_data_ready;
    logic [7:0] RxD_data;
    logic       RxD_frame_err;
    logic       RxD_idle;

    uart_rx_oversampled #(
        .CLK_FREQ   (1843200),
        .BAUD       (115200),
        .OVERSAMPLE (16),
        .IDLE_BITS  (10)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .RxD            (RxD),
        .RxD_data_ready (RxD_data_ready),
        .RxD_data       (RxD_data),
        .RxD_frame_err  (RxD_frame_err),
        .RxD_idle       (RxD_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model: each frame the bench sends produces an expected event with a
    // time window (156 +-1 cycles after the start edge with DIV==1).
    typedef struct {
        bit         good;
        logic [7:0] d;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       expq[$];
    int         rdy_cycs[$];
    logic [7:0] model_data = 8'h00;
    int         idle_drop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Compare process: strobes against the expected-event queue, data every cycle.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (RxD_data_ready && RxD_frame_err) begin
                errors++;
                $display("FAIL both_strobes: ready=1 err=1 at cycle %0d, want at most one", cyc);
            end
            if (RxD_data_ready || RxD_frame_err) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: ready=%0b err=%0b at cycle %0d, want none",
                             RxD_data_ready, RxD_frame_err, cyc);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    if (RxD_data_ready !== e.good || cyc < e.lo || cyc > e.hi) begin
                        errors++;
                        $display("FAIL strobe: ready=%0b at cycle %0d, want ready=%0b in %0d..%0d",
                                 RxD_data_ready, cyc, e.good, e.lo, e.hi);
                    end
                    if (e.good) model_data = e.d;
                    if (RxD_data_ready) rdy_cycs.push_back(cyc);
                end
            end
            if (expq.size() != 0 && cyc > expq[0].hi) begin
                checks++;
                errors++;
                $display("FAIL missing_strobe: none by cycle %0d, want ready=%0b data %0h",
                         cyc, expq[0].good, expq[0].d);
                void'(expq.pop_front());
            end
            checks++;
            if (RxD_data !== model_data) begin
                errors++;
                $display("FAIL data: got %0h want %0h at cycle %0d", RxD_data, model_data, cyc);
            end
        end
    end

    task automatic idle_cycles(input int n);
        RxD = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame, 16 cycles per bit, LSB first; leaves RxD at the stop value.
    task automatic send(input logic [7:0] d, input bit stop_bit, input bit expect_evt);
        exp_t e;
        if (expect_evt) begin
            e.good = stop_bit;
            e.d    = d;
            e.lo   = cyc + 155;
            e.hi   = cyc + 157;
            expq.push_back(e);
        end
        idle_drop = -1;
        RxD = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (idle_drop < 0 && !RxD_idle) idle_drop = i + 1;
        end
        for (int b = 0; b < 8; b++) begin
            RxD = d[b];
            repeat (16) @(negedge clk);
        end
        RxD = stop_bit;
        repeat (16) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"}, {31'd0, RxD_data_ready}, 32'd0);
        chk({name, "_err"},   {31'd0, RxD_frame_err},  32'd0);
        chk({name, "_data"},  {24'd0, RxD_data},       32'd0);
        chk({name, "_idle"},  {31'd0, RxD_idle},       32'd0);
    endtask

    initial begin
        int n;
        int base;
        rst = 1'b0;
        RxD = 1'b1;
        repeat (5) @(negedge clk);
        chk_reset_outputs("reset");

        // Idle rises after 160 ticks of line high following reset release.
        rst = 1'b1;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (RxD_idle && n == 0) n = i;
        end
        chk_rng("idle_after_reset", n, 159, 161);

        // 1: single byte, latency window checked by the compare process.
        idle_cycles(200);
        send(8'hA5, 1'b1, 1'b1);
        idle_cycles(30);
        chk("t1_data", {24'd0, RxD_data}, 32'h0000_00A5);

        // 2: back-to-back frames, no gap.
        base = rdy_cycs.size();
        send(8'h55, 1'b1, 1'b1);
        send(8'h0F, 1'b1, 1'b1);
        idle_cycles(30);
        chk("t2_pulses", rdy_cycs.size() - base, 2);
        if (rdy_cycs.size() - base == 2)
            chk("t2_spacing", rdy_cycs[base+1] - rdy_cycs[base], 160);
        chk("t2_data", {24'd0, RxD_data}, 32'h0000_000F);

        // 3: framing error keeps the previous byte, then a good frame.
        send(8'h3C, 1'b0, 1'b1);
        idle_cycles(40);
        chk("t3_data_kept", {24'd0, RxD_data}, 32'h0000_000F);
        send(8'h81, 1'b1, 1'b1);
        idle_cycles(30);
        chk("t3_data", {24'd0, RxD_data}, 32'h0000_0081);

        // 4: short low glitch is rejected.
        RxD = 1'b0;
        repeat (5) @(negedge clk);
        idle_cycles(60);
        send(8'hFF, 1'b1, 1'b1);
        idle_cycles(30);
        chk("t4_data", {24'd0, RxD_data}, 32'h0000_00FF);

        // 5: line held low through reset release must not decode.
        RxD = 1'b0;
        rst = 1'b0;
        model_data = 8'h00;
        repeat (4) @(negedge clk);
        chk_reset_outputs("t5_reset");
        rst = 1'b1;
        repeat (400) @(negedge clk);
        chk("t5_data_low", {24'd0, RxD_data}, 32'd0);
        idle_cycles(50);
        send(8'h12, 1'b1, 1'b1);
        idle_cycles(30);
        chk("t5_data", {24'd0, RxD_data}, 32'h0000_0012);

        // 6: reset pulse at bit 4 aborts the frame with no strobe.
        RxD = 1'b0;
        repeat (16) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            RxD = (8'hF3 >> b) & 8'h01;
            repeat (16) @(negedge clk);
        end
        RxD = 1'b1;
        rst = 1'b0;
        model_data = 8'h00;
        @(negedge clk);
        chk_reset_outputs("t6_reset");
        rst = 1'b1;
        repeat (15 + 48 + 16) @(negedge clk);
        idle_cycles(30);
        chk("t6_no_strobe", rdy_cycs.size(), base + 5);
        send(8'h5A, 1'b1, 1'b1);
        RxD = 1'b1;
        n = 0;
        for (int i = 0; i < 300 && n == 0; i++) begin
            @(negedge clk);
            if (RxD_idle) n = cyc;
        end
        if (n == 0) begin
            chk("t6_idle_rise_timeout", 32'd0, 32'd1);
        end else if (rdy_cycs.size() != 0) begin
            chk_rng("t6_idle_rise", n - rdy_cycs[rdy_cycs.size()-1], 159, 161);
        end
        chk("t6_data", {24'd0, RxD_data}, 32'h0000_005A);
        send(8'h66, 1'b1, 1'b1);
        chk_rng("t6_idle_drop", idle_drop, 2, 4);
        idle_cycles(30);
        chk("t6_data2", {24'd0, RxD_data}, 32'h0000_0066);

        n = 0;
        while (expq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("queue_drained", expq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- 8N1 asynchronous serial receiver that feeds the 16-bit serial word assembler and interrupt stage.
- Synchronises the raw RxD pin and oversamples each bit. Validates start and stop bits, and delivers each good byte as one-cycle strobe plus data.
- Also reports framing errors and line-idle status for host-side flow control.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, line bit rate
OVERSAMPLE, 16, oversample ticks per bit (power of two, >=8)
IDLE_BITS, 10, idle bit-times after the last frame before RxD_idle asserts

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-low
RxD  input  1  raw asynchronous serial line, idle high
RxD_data_ready  output  1  one-cycle strobe: RxD_data holds a new valid byte
RxD_data  output  8  last good byte received, LSB first on the line
RxD_frame_err  output  1  one-cycle strobe: stop bit sampled low
RxD_idle  output  1  line idle for IDLE_BITS bit-times since the last frame

Behaviour:
- Reset: clk single clock; rst synchronous, active-low.
  - While rst==0 on a rising edge: RxD_data_ready=0, RxD_frame_err=0, RxD_data=8'h00, RxD_idle=0.
  - State IDLE, counters 0, synchroniser flops=1, armed=0.
- Synchroniser: two flops on RxD, reset to 1. All logic uses the synced value rxs only.
- Tick: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), rounded to nearest, minimum 1.
  - tick is high for one cycle every DIV cycles; free-running after reset.
  - With DIV==1, tick is high every cycle.
- Armed: set when rxs==1 is seen on a tick. Prevents a line held low through reset, or a break, from being decoded.
- Per-bit sample counter cnt, 0..OVERSAMPLE-1. Samples at cnt = OVERSAMPLE/2-1, /2, /2+1. Bit value = 2-of-3 majority, decided at cnt==OVERSAMPLE/2+1.
- State IDLE:
  - On a tick with armed and rxs==0: go to START, cnt=0. That tick counts as sample 0.
- State START:
  - At the decision point, majority==1 is a false start: go to IDLE. Low glitches shorter than about OVERSAMPLE/2 ticks are rejected.
  - Majority==0: continue. At cnt==OVERSAMPLE-1, go to DATA with bit index 0.
- State DATA:
  - Shift each decided bit into a shift register, LSB first.
  - After bit 7 ends (cnt==OVERSAMPLE-1), go to STOP.
- State STOP:
  - At the decision point, majority==1: RxD_data <= shift register; RxD_data_ready=1 for exactly one cycle.
  - Majority==0: RxD_frame_err=1 for one cycle, RxD_data unchanged, armed cleared.
  - Either way, return to IDLE immediately (mid-stop-bit), so a following start bit is caught with no gap.
- RxD_data_ready and RxD_frame_err are never both high. Each asserts at most once per frame.
- Latency, DIV==1, OVERSAMPLE==16: falling edge on pin at cycle 0 gives the RxD_data_ready rise at cycle 156. Bench tolerance is ±1.
- Idle counter:
  - Clears and drops RxD_idle when START is entered.
  - Increments on ticks while in IDLE, saturating.
  - RxD_idle=1 when the count reaches IDLE_BITS*OVERSAMPLE.
  - After reset, RxD_idle first asserts after IDLE_BITS*OVERSAMPLE ticks of line high.
- Back-pressure: none. The consumer must accept each strobe; a new byte overwrites RxD_data.
- Reset mid-frame: the frame is aborted, no strobe is issued, and the block re-arms on line high.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE, START, DATA, STOP).
  - Function computing DIV from CLK_FREQ/BAUD/OVERSAMPLE.
  - Constant OVERSAMPLE default.
- Sub-module uart_baud_tick: parameterised divider producing the one-cycle tick. It is reused by the planned transmitter.

Test Plan:
1. Params CLK_FREQ=1843200, BAUD=115200, OVERSAMPLE=16 (DIV=1). Drive byte 8'hA5 with 16 cycles per bit after 200 idle cycles -> one RxD_data_ready pulse at cycle 156±1 after the start edge, RxD_data=8'hA5, RxD_frame_err never high.
2. Back-to-back 8'h55 then 8'h0F, no inter-frame gap -> two ready pulses 160 cycles apart, data 8'h55 then 8'h0F.
3. Frame 8'h3C with stop bit driven 0, then line high, then 8'h81 -> RxD_frame_err one pulse, RxD_data stays 8'h3C-prior value, no ready pulse; then 8'h81 received normally.
4. 5-cycle low glitch on idle line -> no ready, no err, state back in IDLE; next byte 8'hFF received correctly.
5. RxD held low through reset release for 400 cycles, then high 50 cycles, then byte 8'h12 -> no strobes during the low period; 8'h12 received.
6. rst pulsed low at bit 4 of a frame -> outputs 0 next cycle; no strobe for the aborted frame. After a frame ends, RxD_idle rises 160 cycles later and drops at the next start.
